// File: rtl/rms_snr_calculator_pkg.sv
// Shared types, constants and the Q4.4 log2 helper for the RMS / SNR envelope stage.
package rms_snr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SQRT  = 2'd1,
        ST_FLOOR = 2'd2,
        ST_SNR   = 2'd3
    } state_t;

    // Accumulator width for the default 16-bit sample, 256-sample window configuration.
    localparam int ACC_WIDTH = 40;

    localparam logic [16:0] SNR_MULT  = 17'd385;
    localparam int          SNR_SHIFT = 10;

    // Integer part is the MSB index; fraction is the next four bits, zero-padded.
    function automatic logic [7:0] log2_q44(input logic [15:0] x);
        logic [3:0]  msb;
        logic [19:0] scaled;
        msb = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (x[i]) begin
                msb = i[3:0];
            end else begin
                msb = msb;
            end
        end
        scaled = {x, 4'b0000} >> msb;
        return {msb, scaled[3:0]};
    endfunction

endpackage

// File: rtl/rms_snr_calculator_isqrt.sv
// Restoring integer square root, one root bit per cycle MSB first.
// The first bit is resolved on the start edge, so done rises after ROOT_W edges.
module isqrt_seq #(
    parameter int ROOT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [2*ROOT_W-1:0]   radicand,
    output logic                  busy,
    output logic                  done,
    output logic [ROOT_W-1:0]     root
);

    localparam int RAD_W = 2 * ROOT_W;
    localparam int REM_W = ROOT_W + 3;
    localparam int CNT_W = $clog2(ROOT_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ROOT_W - 1);

    logic [RAD_W-1:0]  rad_r, src_rad_s, next_rad_s;
    logic [REM_W-1:0]  rem_r, src_rem_s, shifted_rem_s, trial_s, next_rem_s;
    logic [ROOT_W-1:0] root_r, src_root_s, next_root_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              busy_r, done_r, load_s, bit_s;

    assign load_s = start && !busy_r;

    // One restoring step on either the freshly loaded operand or the working registers.
    always_comb begin
        if (load_s) begin
            src_rad_s  = radicand;
            src_rem_s  = {REM_W{1'b0}};
            src_root_s = {ROOT_W{1'b0}};
        end else begin
            src_rad_s  = rad_r;
            src_rem_s  = rem_r;
            src_root_s = root_r;
        end
        shifted_rem_s = REM_W'({src_rem_s, src_rad_s[RAD_W-1:RAD_W-2]});
        trial_s       = {1'b0, src_root_s, 2'b01};
        if (shifted_rem_s >= trial_s) begin
            next_rem_s = shifted_rem_s - trial_s;
            bit_s      = 1'b1;
        end else begin
            next_rem_s = shifted_rem_s;
            bit_s      = 1'b0;
        end
        next_root_s = ROOT_W'({src_root_s, bit_s});
        next_rad_s  = RAD_W'({src_rad_s, 2'b00});
    end

    // Iteration registers and the busy/done handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rad_r  <= {RAD_W{1'b0}};
            rem_r  <= {REM_W{1'b0}};
            root_r <= {ROOT_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (load_s || busy_r) begin
            rad_r  <= next_rad_s;
            rem_r  <= next_rem_s;
            root_r <= next_root_s;
            if (load_s) begin
                cnt_r  <= CNT_W'(1);
                busy_r <= 1'b1;
                done_r <= 1'b0;
            end else if (cnt_r == LAST_STEP) begin
                cnt_r  <= {CNT_W{1'b0}};
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                cnt_r  <= cnt_r + CNT_W'(1);
                busy_r <= 1'b1;
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign root = root_r;

endmodule

// File: rtl/rms_snr_calculator.sv
// Windowed mean-square energy, sequential RMS, slow-rising noise floor and integer-dB SNR.
module rms_snr_calculator
    import rms_snr_pkg::*;
#(
    parameter int SAMPLE_WIDTH     = 16,
    parameter int WINDOW_LOG2      = 8,
    parameter int FLOOR_RISE_SHIFT = 6
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic                    sample_in_valid,
    output logic [SAMPLE_WIDTH-1:0] signal_rms,
    output logic [SAMPLE_WIDTH-1:0] snr_db,
    output logic                    rms_valid,
    output logic                    overrun
);

    localparam int SQ_W  = 2 * SAMPLE_WIDTH;
    localparam int ACC_W = ACC_WIDTH + 2 * (SAMPLE_WIDTH - 16) + (WINDOW_LOG2 - 8);
    localparam int FW    = SAMPLE_WIDTH + 1;

    logic signed [SQ_W-1:0]   sample_ext_s;
    logic [SQ_W-1:0]          sq_s, mean_sq_s;
    logic [ACC_W-1:0]         acc_r, acc_sum_s;
    logic [WINDOW_LOG2-1:0]   count_r;
    logic                     window_end_s, start_s, sqrt_busy_s, sqrt_done_s;
    logic [SAMPLE_WIDTH-1:0]  root_s, floor_r, floor_cand_s, floor_next_s;
    logic [FW-1:0]            floor_rise_s;
    logic                     first_r;
    state_t                   state_r;
    logic [7:0]               l_rms_s, l_floor_s, diff_s;
    logic [16:0]              snr_prod_s, snr_scaled_s;
    logic [SAMPLE_WIDTH-1:0]  signal_rms_r, snr_db_r;
    logic                     rms_valid_r, overrun_r;

    assign sample_ext_s = {{SAMPLE_WIDTH{sample[SAMPLE_WIDTH-1]}}, sample};
    assign sq_s         = sample_ext_s * sample_ext_s;
    assign acc_sum_s    = acc_r + ACC_W'(sq_s);
    assign mean_sq_s    = acc_sum_s[ACC_W-1:WINDOW_LOG2];
    assign window_end_s = sample_in_valid && (&count_r);
    assign start_s      = window_end_s && (state_r == ST_IDLE) && !sqrt_busy_s;

    // Energy accumulator and window counter, independent of the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_r   <= {ACC_W{1'b0}};
            count_r <= {WINDOW_LOG2{1'b0}};
        end else if (sample_in_valid) begin
            count_r <= count_r + WINDOW_LOG2'(1);
            if (window_end_s) begin
                acc_r <= {ACC_W{1'b0}};
            end else begin
                acc_r <= acc_sum_s;
            end
        end else begin
            acc_r   <= acc_r;
            count_r <= count_r;
        end
    end

    // The square-root unit's operand register holds the window's mean square.
    isqrt_seq #(
        .ROOT_W   (SAMPLE_WIDTH)
    ) u_isqrt (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start_s),
        .radicand (mean_sq_s),
        .busy     (sqrt_busy_s),
        .done     (sqrt_done_s),
        .root     (root_s)
    );

    // Noise-floor candidate: track downward immediately, leak upward slowly, never zero.
    always_comb begin
        floor_rise_s = {1'b0, floor_r} + FW'(floor_r >> FLOOR_RISE_SHIFT) + FW'(1);
        if (first_r) begin
            floor_cand_s = root_s;
        end else if (root_s < floor_r) begin
            floor_cand_s = root_s;
        end else if (floor_rise_s[SAMPLE_WIDTH]) begin
            floor_cand_s = {SAMPLE_WIDTH{1'b1}};
        end else begin
            floor_cand_s = floor_rise_s[SAMPLE_WIDTH-1:0];
        end
        if (floor_cand_s == {SAMPLE_WIDTH{1'b0}}) begin
            floor_next_s = SAMPLE_WIDTH'(1);
        end else begin
            floor_next_s = floor_cand_s;
        end
    end

    // Log-domain difference scaled to dB.
    always_comb begin
        l_rms_s   = log2_q44(root_s);
        l_floor_s = log2_q44(floor_r);
        if (l_rms_s > l_floor_s) begin
            diff_s = l_rms_s - l_floor_s;
        end else begin
            diff_s = 8'd0;
        end
        snr_prod_s   = {9'd0, diff_s} * SNR_MULT;
        snr_scaled_s = snr_prod_s >> SNR_SHIFT;
    end

    // Control FSM, floor state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            floor_r      <= {SAMPLE_WIDTH{1'b0}};
            first_r      <= 1'b1;
            signal_rms_r <= {SAMPLE_WIDTH{1'b0}};
            snr_db_r     <= {SAMPLE_WIDTH{1'b0}};
            rms_valid_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            rms_valid_r <= 1'b0;
            if (window_end_s && !start_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r <= ST_SQRT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SQRT: begin
                    if (sqrt_done_s) begin
                        state_r <= ST_FLOOR;
                    end else begin
                        state_r <= ST_SQRT;
                    end
                end
                ST_FLOOR: begin
                    floor_r <= floor_next_s;
                    first_r <= 1'b0;
                    state_r <= ST_SNR;
                end
                ST_SNR: begin
                    signal_rms_r <= root_s;
                    snr_db_r     <= SAMPLE_WIDTH'(snr_scaled_s);
                    rms_valid_r  <= 1'b1;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign signal_rms = signal_rms_r;
    assign snr_db     = snr_db_r;
    assign rms_valid  = rms_valid_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_rms_snr_calculator.sv
// Self-checking bench: table-driven windows plus reset and overrun sequences, scoreboard on rms_valid.
module tb_rms_snr_calculator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] sample_a, sample_b;
    logic        valid_a, valid_b;
    logic [15:0] signal_rms_a, snr_db_a, signal_rms_b, snr_db_b;
    logic        rms_valid_a, overrun_a, rms_valid_b, overrun_b;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] rms;
        logic [15:0] snr;
        int          due;
    } exp_t;

    typedef struct {
        int          val;
        bit          alt;
        logic [15:0] rms;
        logic [15:0] snr;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    vec_t tbl[6];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    rms_snr_calculator #(
        .SAMPLE_WIDTH     (16),
        .WINDOW_LOG2      (8),
        .FLOOR_RISE_SHIFT (6)
    ) dut_a (
        .clk             (clk),
        .reset_n         (reset_n),
        .sample          (sample_a),
        .sample_in_valid (valid_a),
        .signal_rms      (signal_rms_a),
        .snr_db          (snr_db_a),
        .rms_valid       (rms_valid_a),
        .overrun         (overrun_a)
    );

    rms_snr_calculator #(
        .SAMPLE_WIDTH     (16),
        .WINDOW_LOG2      (2),
        .FLOOR_RISE_SHIFT (6)
    ) dut_b (
        .clk             (clk),
        .reset_n         (reset_n),
        .sample          (sample_b),
        .sample_in_valid (valid_b),
        .signal_rms      (signal_rms_b),
        .snr_db          (snr_db_b),
        .rms_valid       (rms_valid_b),
        .overrun         (overrun_b)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and score any rms_valid pulse seen there.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rms_valid_a) begin
            if (qa.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL a_unexpected_pulse: got rms_valid=1 expected no pulse (rms=%0d)", signal_rms_a);
            end else begin
                e = qa.pop_front();
                check("a_rms", signal_rms_a, e.rms);
                check("a_snr", snr_db_a, e.snr);
                check("a_latency", 16'(cyc), 16'(e.due));
            end
        end
        if (rms_valid_b) begin
            if (qb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL b_unexpected_pulse: got rms_valid=1 expected no pulse (rms=%0d)", signal_rms_b);
            end else begin
                e = qb.pop_front();
                check("b_rms", signal_rms_b, e.rms);
                check("b_snr", snr_db_b, e.snr);
                check("b_latency", 16'(cyc), 16'(e.due));
            end
        end
    endtask

    task automatic send_a(input int val, input bit alt, input int n, input bit push,
                          input logic [15:0] er, input logic [15:0] es);
        for (int i = 0; i < n; i++) begin
            tick();
            sample_a = (alt && (i % 2 == 1)) ? 16'(-val) : 16'(val);
            valid_a  = 1'b1;
            if (push && (i == n - 1)) qa.push_back('{er, es, cyc + 19});
        end
        tick();
        valid_a  = 1'b0;
        sample_a = 16'd0;
    endtask

    task automatic drain();
        for (int k = 0; k < 80; k++) begin
            if (qa.size() != 0 || qb.size() != 0) tick();
        end
        check("drain_a", 16'(qa.size()), 16'd0);
        check("drain_b", 16'(qb.size()), 16'd0);
        qa.delete();
        qb.delete();
    endtask

    initial begin
        tbl[0] = '{100,    1'b1, 16'd100,   16'd0};
        tbl[1] = '{6400,   1'b1, 16'd6400,  16'd36};
        tbl[2] = '{0,      1'b0, 16'd0,     16'd0};
        tbl[3] = '{-32768, 1'b0, 16'd32768, 16'd84};
        tbl[4] = '{1000,   1'b0, 16'd1000,  16'd50};
        tbl[5] = '{255,    1'b0, 16'd255,   16'd35};

        reset_n  = 1'b1;
        valid_a  = 1'b0;
        valid_b  = 1'b0;
        sample_a = 16'd0;
        sample_b = 16'd0;
        #2 reset_n = 1'b0;
        repeat (3) tick();
        check("rst_rms_a", signal_rms_a, 16'd0);
        check("rst_snr_a", snr_db_a, 16'd0);
        check("rst_valid_a", {15'd0, rms_valid_a}, 16'd0);
        check("rst_overrun_a", {15'd0, overrun_a}, 16'd0);
        check("rst_rms_b", signal_rms_b, 16'd0);
        check("rst_overrun_b", {15'd0, overrun_b}, 16'd0);
        reset_n = 1'b1;

        // First window after reset: constant 1000, latency 18 after the last valid.
        send_a(1000, 1'b0, 256, 1'b1, 16'd1000, 16'd0);
        drain();

        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        for (int v = 0; v < 6; v++) begin
            send_a(tbl[v].val, tbl[v].alt, 256, 1'b1, tbl[v].rms, tbl[v].snr);
            drain();
        end

        // Reset during SQRT: outputs clear at once, the interrupted window never reports.
        send_a(700, 1'b0, 256, 1'b0, 16'd0, 16'd0);
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        check("midrst_rms", signal_rms_a, 16'd0);
        check("midrst_snr", snr_db_a, 16'd0);
        check("midrst_valid", {15'd0, rms_valid_a}, 16'd0);
        tick();
        tick();
        reset_n = 1'b1;
        repeat (30) tick();
        send_a(700, 1'b0, 255, 1'b0, 16'd0, 16'd0);
        repeat (30) tick();
        send_a(700, 1'b0, 1, 1'b1, 16'd700, 16'd0);
        drain();
        check("a_no_overrun", {15'd0, overrun_a}, 16'd0);

        // Back-to-back windows of 4: only the first is processed, the rest overrun.
        for (int i = 0; i < 12; i++) begin
            tick();
            sample_b = (i < 4) ? 16'd300 : 16'd5000;
            valid_b  = 1'b1;
            if (i == 3) qb.push_back('{16'd300, 16'd0, cyc + 19});
        end
        tick();
        valid_b = 1'b0;
        check("b_overrun_set", {15'd0, overrun_b}, 16'd1);
        drain();
        check("b_overrun_sticky", {15'd0, overrun_b}, 16'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            sample_b = 16'd600;
            valid_b  = 1'b1;
            if (i == 3) qb.push_back('{16'd600, 16'd5, cyc + 19});
        end
        tick();
        valid_b = 1'b0;
        drain();
        check("b_overrun_final", {15'd0, overrun_b}, 16'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rms_snr_calculator.md
# rms_snr_calculator

Windowed energy-envelope stage directly upstream of the beat/BPM detector. Squares each incoming audio sample and averages over a fixed power-of-two window, then takes a sequential integer square root to produce `signal_rms`. It also tracks a slow-rising noise floor and emits `snr_db`, with a one-cycle `rms_valid` strobe that drives the detector's `sample_valid` input.

## Interface
- `SAMPLE_WIDTH`, default 16: signed audio sample width; also the width of `signal_rms` and `snr_db`.
- `WINDOW_LOG2`, default 8: window length is 2^WINDOW_LOG2 samples (256).
- `FLOOR_RISE_SHIFT`, default 6: noise-floor upward leak per window is `(floor >> FLOOR_RISE_SHIFT) + 1`.
- `clk` in 1: system clock. One clock domain only.
- `reset_n` in 1: asynchronous reset, active-low.
- `sample` in SAMPLE_WIDTH: signed two's-complement audio sample.
- `sample_in_valid` in 1: qualifies `sample` for one cycle.
- `signal_rms` out SAMPLE_WIDTH: RMS of the last completed window, unsigned.
- `snr_db` out SAMPLE_WIDTH: 20·log10(rms/floor), integer dB, zero-extended, range 0..96.
- `rms_valid` out 1: one-cycle pulse when `signal_rms` and `snr_db` update together.
- `overrun` out 1: sticky flag, cleared only by reset.

## Operation
- Accumulator: 2·SAMPLE_WIDTH+WINDOW_LOG2 bits (40). On each `sample_in_valid`, add `sample*sample` (signed square, 32-bit unsigned result) and increment the window counter (WINDOW_LOG2 bits). The accumulator runs regardless of FSM state.
- Window end: on the sample that wraps the counter to 0, `mean_sq = (acc + sq) >> WINDOW_LOG2` (32 bits) is latched into a holding register. The accumulator clears to 0 in the same cycle.
- FSM states: IDLE → SQRT (exactly 16 cycles, restoring, one result bit per cycle, MSB first) → FLOOR (1 cycle) → SNR (1 cycle) → IDLE.
- Window end while the FSM is not in IDLE: drop that window's `mean_sq`, set `overrun`, and keep the FSM on its current job.
- FLOOR state:
  - First window after reset: `floor = rms`.
  - Later windows: if `rms < floor`, `floor = rms`; otherwise `floor = min(0xFFFF, floor + (floor >> FLOOR_RISE_SHIFT) + 1)`.
  - In all cases, clamp `floor` to at least 1.
- log2 approximation L(x), 8-bit Q4.4:
  - Integer part = index of the MSB.
  - Fraction = the 4 bits immediately below the MSB, zero-padded if fewer exist.
  - L(0) = L(1) = 0.
- SNR state:
  - `diff = L(rms) − L(floor)`, clamped to ≥ 0.
  - `snr_db = (diff * 385) >> 10`, giving 0.376 dB per 1/16 octave.
  - SNR uses the floor value updated in FLOOR.
- Outputs are registered and update only at the SNR→IDLE transition. They hold their value between updates.

## Timing
- Reset values: `signal_rms` = 0, `snr_db` = 0, `rms_valid` = 0, `overrun` = 0, accumulator = 0, counter = 0, floor = 0 with the first-window flag set, FSM = IDLE.
- Edge E0 samples the window's final `sample_in_valid`. E1..E16 are SQRT, E17 is FLOOR, E18 is SNR. New outputs and `rms_valid` = 1 are visible after E18, for exactly one cycle. Latency is 18 cycles.
- The minimum spacing of `sample_in_valid` without overrun is 2^WINDOW_LOG2 samples per 19 cycles. At 30.72 kHz on 18.432 MHz there is a 600-cycle sample spacing, so overrun is impossible in normal operation.
- Reset asserted mid-operation: all state returns to reset values asynchronously. `rms_valid` never fires for the interrupted window, and the next window is a full 2^WINDOW_LOG2 fresh samples.

## Structure
- Package `rms_snr_pkg`:
  - FSM state enum (IDLE, SQRT, FLOOR, SNR).
  - `ACC_WIDTH` constant.
  - SNR multiplier (385) and shift (10) constants.
  - `log2_q44` function.
- Sub-module `isqrt_seq`: 32-bit radicand in, 16-bit root out. Ports are `start`, `busy`, and a `done` pulse after 16 cycles. The top-level SQRT state waits on it.

## Test plan
- Constant `sample` = 1000 for 256 valids → `signal_rms` = 1000, `snr_db` = 0 (first window), `rms_valid` pulses once, 18 cycles after the last valid.
- Window 1 at ±100, window 2 at ±6400:
  - After window 2: `floor` = 102, L(6400) = 201, L(102) = 105, `snr_db` = 36, `signal_rms` = 6400.
- All-zero window → `signal_rms` = 0, floor clamps to 1, `snr_db` = 0.
- Full-scale −32768 for 256 samples → `mean_sq` = 2^30, `signal_rms` = 32768, no accumulator overflow.
- Deassert `reset_n` during SQRT:
  - All outputs read 0 immediately, with no `rms_valid`.
  - After release, exactly 256 new samples are needed before the next pulse.
- Drive `sample_in_valid` every cycle with WINDOW_LOG2 = 2:
  - `overrun` goes to 1 and stays set.
  - Dropped windows produce no `rms_valid`.
  - The in-flight window still completes correctly.
